// File: rtl/avalon_write_buffer_if.sv
// Controller, SRAM and status signals of the Avalon write buffer.
// slave is the buffer's view; master is the controller/SRAM side.
interface avalon_write_buffer_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              w_ena;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              rd_busy;
  logic              calc_busy;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_wen;
  logic              sram_ren;
  logic [DATA_W-1:0] sram_rdata;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow_err;
  logic              clear_err;

  modport slave (
    input  w_ena, w_addr, w_data,
    input  r_req, r_addr,
    input  calc_busy, sram_rdata, clear_err,
    output r_data, r_valid, rd_busy,
    output sram_addr, sram_wdata,
    output sram_wen, sram_ren,
    output full, empty, count,
    output overflow_err
  );

  modport master (
    output w_ena, w_addr, w_data,
    output r_req, r_addr,
    output calc_busy, sram_rdata, clear_err,
    input  r_data, r_valid, rd_busy,
    input  sram_addr, sram_wdata,
    input  sram_wen, sram_ren,
    input  full, empty, count,
    input  overflow_err
  );
endinterface

// File: rtl/avalon_write_buffer.sv
// Write FIFO between the Avalon controller and the sample SRAM.
// Drains while the calc engine is idle; reads queue behind writes.
module avalon_write_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  avalon_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RD_FLUSH,
    RD_ISSUE,
    RD_DATA
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              r_valid_q, r_valid_d;
  logic              ovf_q, ovf_d;

  logic is_full;
  logic is_empty;
  logic pop;
  logic push;
  logic rd_issue;

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);

  // Draining is only allowed outside the read issue/data phases.
  assign pop = ((state_q == IDLE) || (state_q == RD_FLUSH))
             && !bus.calc_busy && !is_empty;
  assign push     = bus.w_ena && (!is_full || pop);
  assign rd_issue = (state_q == RD_ISSUE) && !bus.calc_busy;

  always_comb begin : fifo_next
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (pop)  head_d = head_q + PW'(1);
    if (push) tail_d = tail_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (bus.w_ena && !push) begin
      ovf_d = 1'b1;
    end else if (bus.clear_err) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin : fsm_next
    state_d   = state_q;
    r_addr_d  = r_addr_q;
    r_data_d  = r_data_q;
    r_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.r_req) begin
          r_addr_d = bus.r_addr;
          state_d  = RD_FLUSH;
        end
      end
      RD_FLUSH: begin
        if (count_d == '0) state_d = RD_ISSUE;
      end
      RD_ISSUE: begin
        if (rd_issue) state_d = RD_DATA;
      end
      RD_DATA: begin
        r_data_d  = bus.sram_rdata;
        r_valid_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : sram_drive
    bus.sram_wen   = 1'b0;
    bus.sram_ren   = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (pop) begin
      bus.sram_wen   = 1'b1;
      bus.sram_addr  = addr_mem_q[head_q];
      bus.sram_wdata = data_mem_q[head_q];
    end else if (rd_issue) begin
      bus.sram_ren  = 1'b1;
      bus.sram_addr = r_addr_q;
    end
  end

  // Entry storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[tail_q] <= bus.w_addr;
      data_mem_q[tail_q] <= bus.w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      r_addr_q  <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      r_addr_q  <= r_addr_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.r_data       = r_data_q;
  assign bus.r_valid      = r_valid_q;
  assign bus.rd_busy      = (state_q != IDLE);
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.count        = count_q;
  assign bus.overflow_err = ovf_q;
endmodule

// File: tb/tb_avalon_write_buffer.sv
// Scoreboard bench for avalon_write_buffer with an SRAM model.
// Expected writes/reads are queued by the driver, checked by a monitor.
module tb_avalon_write_buffer;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  avalon_write_buffer_if #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) bus ();

  avalon_write_buffer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] sram    [2**ADDR_W];
  logic [DATA_W-1:0] mem_ref [2**ADDR_W];

  always @(posedge clk) begin
    if (bus.sram_wen) sram[bus.sram_addr] <= bus.sram_wdata;
    if (bus.sram_ren) bus.sram_rdata <= sram[bus.sram_addr];
  end

  wr_t               exp_wq [$];
  logic [DATA_W-1:0] exp_rq [$];

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Latest queued write to an address wins, else what has landed.
  function automatic logic [DATA_W-1:0] rd_model(logic [ADDR_W-1:0] a);
    for (int i = exp_wq.size() - 1; i >= 0; i--)
      if (exp_wq[i].a == a) return exp_wq[i].d;
    return mem_ref[a];
  endfunction

  always @(negedge clk) begin
    wr_t w;
    logic [DATA_W-1:0] rd;
    if (!rst) begin
      if (bus.sram_wen || bus.sram_ren) begin
        chk("access_while_busy", 32'(bus.calc_busy), 32'd0);
        chk("wen_ren_overlap", 32'(bus.sram_wen & bus.sram_ren), 32'd0);
      end
      if (bus.sram_wen) begin
        checks++;
        if (exp_wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h",
                   bus.sram_addr, bus.sram_wdata);
        end else begin
          w = exp_wq.pop_front();
          chk("wr_addr", 32'(bus.sram_addr), 32'(w.a));
          chk("wr_data", 32'(bus.sram_wdata), 32'(w.d));
          mem_ref[w.a] = w.d;
        end
      end
      if (bus.r_valid) begin
        checks++;
        if (exp_rq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid: data %0h", bus.r_data);
        end else begin
          rd = exp_rq.pop_front();
          chk("r_data", 32'(bus.r_data), 32'(rd));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_w(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d,
                        bit expect_ok);
    bus.w_ena  = 1'b1;
    bus.w_addr = a;
    bus.w_data = d;
    if (expect_ok) exp_wq.push_back('{a: a, d: d});
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while ((exp_wq.size() != 0 || exp_rq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      sram[i]    = '0;
      mem_ref[i] = '0;
    end
    bus.w_ena = 0; bus.w_addr = '0; bus.w_data = '0;
    bus.r_req = 0; bus.r_addr = '0;
    bus.calc_busy = 0; bus.clear_err = 0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_rvalid", 32'(bus.r_valid), 32'd0);
    chk("rst_rdbusy", 32'(bus.rd_busy), 32'd0);
    chk("rst_ovf", 32'(bus.overflow_err), 32'd0);
    chk("rst_wen", 32'(bus.sram_wen), 32'd0);
    chk("rst_ren", 32'(bus.sram_ren), 32'd0);
    chk("rst_rdata", 32'(bus.r_data), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Three pushes drain back to back
    for (int i = 0; i < 3; i++) begin
      push_w(ADDR_W'(16 + i), DATA_W'(16'hA0A0 + i), 1'b1);
      step();
      if (i == 0) chk("first_wen_latency", 32'(bus.sram_wen), 32'd1);
    end
    bus.w_ena = 0;
    step();
    step();
    chk("drained_empty", 32'(bus.empty), 32'd1);
    chk("drained_count", 32'(bus.count), 32'd0);

    // Fill while busy, overflow, clear, drain
    bus.calc_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      push_w(ADDR_W'(i), DATA_W'(16'hB000 + i), 1'b1);
      step();
    end
    bus.w_ena = 0;
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'(DEPTH));
    push_w(ADDR_W'(12'h0FF), 16'hDEAD, 1'b0);
    step();
    bus.w_ena = 0;
    chk("ovf_set", 32'(bus.overflow_err), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'(DEPTH));
    bus.clear_err = 1'b1;
    step();
    bus.clear_err = 1'b0;
    chk("ovf_cleared", 32'(bus.overflow_err), 32'd0);
    bus.calc_busy = 1'b0;
    wait_drain(50);

    // Full with simultaneous pop and push, pointer wrap
    bus.calc_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      push_w(ADDR_W'(12'h100 + i), DATA_W'($urandom), 1'b1);
      step();
    end
    bus.calc_busy = 1'b0;
    for (int i = DEPTH; i < 20; i++) begin
      push_w(ADDR_W'(12'h100 + i), DATA_W'($urandom), 1'b1);
      step();
      chk("pushpop_count", 32'(bus.count), 32'(DEPTH));
    end
    bus.w_ena = 0;
    chk("pushpop_ovf", 32'(bus.overflow_err), 32'd0);
    wait_drain(50);

    // Same-cycle write and read to one address
    push_w(ADDR_W'(5), 16'h1234, 1'b1);
    bus.r_req  = 1'b1;
    bus.r_addr = ADDR_W'(5);
    exp_rq.push_back(rd_model(ADDR_W'(5)));
    step();
    bus.w_ena = 0;
    bus.r_req = 0;
    wait_drain(50);

    // Read held in RD_ISSUE by calc_busy
    bus.calc_busy = 1'b1;
    bus.r_req  = 1'b1;
    bus.r_addr = ADDR_W'(5);
    exp_rq.push_back(rd_model(ADDR_W'(5)));
    step();
    bus.r_req = 0;
    step();
    for (int k = 0; k < 5; k++) begin
      bus.r_req  = (k == 2);
      bus.r_addr = ADDR_W'(12'h7FF);
      chk("hold_ren_low", 32'(bus.sram_ren), 32'd0);
      chk("hold_rdbusy", 32'(bus.rd_busy), 32'd1);
      step();
    end
    bus.r_req = 0;
    bus.calc_busy = 1'b0;
    #1;
    chk("issue_ren", 32'(bus.sram_ren), 32'd1);
    chk("issue_addr", 32'(bus.sram_addr), 32'd5);
    step();
    chk("rvalid_c1", 32'(bus.r_valid), 32'd0);
    step();
    chk("rvalid_c2", 32'(bus.r_valid), 32'd1);
    chk("rdata_c2", 32'(bus.r_data), 32'h1234);
    step();
    chk("rvalid_pulse", 32'(bus.r_valid), 32'd0);
    repeat (8) step();
    chk("no_second_rd", 32'(bus.rd_busy), 32'd0);

    // Reset with pending writes and a read in RD_FLUSH
    bus.calc_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_w(ADDR_W'(12'h200 + i), DATA_W'($urandom), 1'b1);
      step();
    end
    bus.w_ena  = 0;
    bus.r_req  = 1'b1;
    bus.r_addr = ADDR_W'(12'h200);
    exp_rq.push_back(rd_model(ADDR_W'(12'h200)));
    step();
    bus.r_req = 0;
    step();
    chk("pre_rst_busy", 32'(bus.rd_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_empty", 32'(bus.empty), 32'd1);
    chk("mid_rst_rdbusy", 32'(bus.rd_busy), 32'd0);
    chk("mid_rst_rdata", 32'(bus.r_data), 32'd0);
    chk("mid_rst_wen", 32'(bus.sram_wen), 32'd0);
    chk("mid_rst_ren", 32'(bus.sram_ren), 32'd0);
    chk("mid_rst_addr", 32'(bus.sram_addr), 32'd0);
    exp_wq.delete();
    exp_rq.delete();
    step();
    step();
    rst = 1'b0;
    bus.calc_busy = 1'b0;
    repeat (10) step();
    chk("post_rst_idle", 32'(bus.rd_busy), 32'd0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      bus.w_ena = 0;
      bus.r_req = 0;
      bus.calc_busy = ($urandom_range(0, 9) < 3);
      if (exp_rq.size() == 0) begin
        if (exp_wq.size() < DEPTH && $urandom_range(0, 1) == 1) begin
          a = ADDR_W'($urandom_range(0, 31));
          d = DATA_W'($urandom);
          push_w(a, d, 1'b1);
        end
        if ($urandom_range(0, 9) == 0) begin
          bus.r_req  = 1'b1;
          bus.r_addr = ADDR_W'($urandom_range(0, 31));
          exp_rq.push_back(rd_model(bus.r_addr));
        end
      end
      step();
    end
    bus.w_ena = 0;
    bus.r_req = 0;
    bus.calc_busy = 1'b0;
    wait_drain(200);
    chk("final_ovf", 32'(bus.overflow_err), 32'd0);
    chk("final_empty", 32'(bus.empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/avalon_write_buffer.md
Name: avalon_write_buffer

Overview:
- Sits directly downstream of the Avalon slave controller.
- Absorbs its single-word and burst write strobes (w_ena, address, 16-bit data) into a small FIFO.
- Drains the FIFO into the single-port sample SRAM whenever the calculation engine is not using that SRAM.
- Serves read requests from the controller in order behind all pending writes, so the controller never stalls on SRAM arbitration and reads never return stale data.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of two, at least 2.
- ADDR_W, 11, SRAM word-address width; matches the controller output_address.
- DATA_W, 16, stored data width; the controller supplies writedata[15:0].

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- w_ena  in  1  push strobe from the controller; one entry per cycle high.
- w_addr  in  ADDR_W  write address, sampled with w_ena.
- w_data  in  DATA_W  write data, sampled with w_ena.
- r_req  in  1  single-cycle read request pulse.
- r_addr  in  ADDR_W  read address, sampled with r_req.
- r_data  out  DATA_W  read result, registered.
- r_valid  out  1  one-cycle pulse; r_data is valid while it is high.
- rd_busy  out  1  high from the cycle after r_req is accepted until r_valid is seen.
- calc_busy  in  1  calculation engine owns the SRAM; block issues no SRAM access while high.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_wen  out  1  SRAM write enable.
- sram_ren  out  1  SRAM read enable; sram_rdata is valid one cycle later.
- sram_rdata  in  DATA_W  SRAM read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow_err  out  1  sticky flag: a push was dropped.
- clear_err  in  1  synchronous clear of overflow_err.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: FIFO pointers and count 0, so empty=1 and full=0. r_data=0, r_valid=0, rd_busy=0, overflow_err=0, state IDLE. All sram_* outputs 0.
- Reset mid-operation: FIFO contents and any pending read are discarded; no r_valid is produced.
- Push: on an edge with w_ena=1, {w_addr, w_data} is written at the tail and the tail pointer wraps modulo DEPTH.
- Full with no pop in the same cycle: the push is dropped and overflow_err sets at that edge.
- Full with a pop in the same cycle: the push is accepted and count is unchanged.
- clear_err has priority below a same-cycle overflow, so overflow_err stays 1 in that case.
- Drain condition: in IDLE or RD_FLUSH with empty=0 and calc_busy=0.
- Drain outputs: sram_wen=1 and sram_addr/sram_wdata = head entry, combinationally. The head pops at that edge.
- Drain rate and latency: one write per cycle; the earliest SRAM write is the cycle after the push.
- Outputs otherwise: sram_wen=0, sram_ren=0, and sram_addr/sram_wdata driven to 0.
- State machine, IDLE: on r_req, latch r_addr into r_addr_q and go to RD_FLUSH.
- RD_FLUSH: drain normally; go to RD_ISSUE when empty=1 at the edge (after any pop and push in that cycle). Writes pushed while here are accepted and must drain before the read.
- RD_ISSUE: when calc_busy=0, drive sram_ren=1 with sram_addr=r_addr_q and go to RD_DATA. Otherwise hold with all SRAM enables low.
- RD_DATA: load r_data from sram_rdata, set r_valid for exactly one cycle, and go to IDLE.
- Read ordering: no draining happens in RD_ISSUE or RD_DATA.
- Read latency with FIFO empty and calc_busy low: r_req sampled at edge E0, RD_FLUSH after E0, RD_ISSUE after E1, RD_DATA after E2, r_valid high in the cycle after E3.
- Ignored requests: r_req while rd_busy=1 is ignored.
- Simultaneous w_ena and r_req in IDLE: the write is pushed and the read waits for it.
- sram_wen and sram_ren are never high together, and never high while calc_busy=1.

Test Plan:
- Reset, then push 3 words (addr 0x010..0x012, data 0xA0A0..0xA0A2) with calc_busy=0 -> three consecutive sram_wen cycles starting the cycle after the first push, in order; then empty=1, count=0.
- calc_busy=1, push 8 words, then a 9th (addr 0x0FF) -> full=1 and count=8. The 9th push is dropped and overflow_err=1; clear_err clears it. Release calc_busy -> exactly 8 writes, the last addr 0x007.
- Full with calc_busy=0: push and pop in the same cycle -> push accepted, count stays 8, overflow_err stays 0. Verify pointer wrap by pushing 20 words total with correct write order.
- Push 0x1234 to addr 0x05 and pulse r_req addr 0x05 in the same cycle. The SRAM model returns the stored data -> the SRAM write precedes the read, and r_valid carries r_data=0x1234.
- Read pending in RD_ISSUE with calc_busy=1 for 5 cycles -> sram_ren stays low; r_valid comes 2 cycles after calc_busy falls. A second r_req during rd_busy produces no second r_valid.
- Assert rst with 4 entries pending and a read in RD_FLUSH -> all outputs return to their reset values immediately, with no further sram_wen and no r_valid.
